fetch_pc_seq: RTL and testbench

//  Instruction-fetch sequencer; drives the 4-bit next-PC 2:1 mux.
//  - Fetch side:
//    - Presents pc_inc (PC+1) on the mux's in0 and br_tgt on its in1.
//    - Drives the mux sel with br_sel and registers the mux output (next_pc) as the PC.
//  - Decode side: hands fetched instructions to decode over a valid/ready handshake.
//  - Sequencing: handles stall, branch redirect with a one-cycle flush, and HALT/resume.

---
 rtl/fetch_pc_seq_if.sv | 35 +++
 rtl/fetch_pc_seq.sv | 80 ++++++++
 tb/tb_fetch_pc_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_seq_if.sv
// Bus bundle between the fetch sequencer and its surroundings:
// instruction memory, external next-PC mux, execute redirect and decode.
interface fetch_pc_seq_if #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 8,
    parameter int CNT_W   = 8
);
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    br_tgt;
    logic               br_sel;
    logic [PC_W-1:0]    next_pc;
    logic               br_req;
    logic [PC_W-1:0]    br_target;
    logic               resume;
    logic               id_ready;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               halted;
    logic [CNT_W-1:0]   fetch_cnt;

    modport master (
        output imem_addr, pc_inc, br_tgt, br_sel,
        output if_valid, if_instr, if_pc, halted, fetch_cnt,
        input  imem_rdata, next_pc, br_req, br_target, resume, id_ready
    );

    modport slave (
        input  imem_addr, pc_inc, br_tgt, br_sel,
        input  if_valid, if_instr, if_pc, halted, fetch_cnt,
        output imem_rdata, next_pc, br_req, br_target, resume, id_ready
    );
endinterface

// File: rtl/fetch_pc_seq.sv
// Instruction-fetch sequencer: owns the PC register, feeds the external next-PC mux
// and hands instructions to decode with stall, branch flush and HALT/resume handling.
module fetch_pc_seq #(
    parameter int              PC_W     = 4,
    parameter int              INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF,
    parameter int              CNT_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_seq_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

    state_t           state, state_nxt;
    logic [PC_W-1:0]  pc, pc_nxt;
    logic [CNT_W-1:0] cnt;
    logic             valid, accept, is_halt;

    assign is_halt = (bus.imem_rdata[INSTR_W-1 -: 4] == HALT_OP);
    assign valid   = (state == RUN);
    assign accept  = valid & bus.id_ready;

    // Mux inputs are purely combinational so the next_pc loop closes in one cycle.
    assign bus.imem_addr = pc;
    assign bus.pc_inc    = pc + PC_W'(1);
    assign bus.br_tgt    = bus.br_target;
    assign bus.br_sel    = bus.br_req;

    assign bus.if_valid  = valid;
    assign bus.if_instr  = valid ? bus.imem_rdata : '0;
    assign bus.if_pc     = valid ? pc : '0;
    assign bus.halted    = (state == HALT);
    assign bus.fetch_cnt = cnt;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        // A redirect wins over stall, halt detection and resume.
        if (bus.br_req) begin
            pc_nxt    = bus.next_pc;
            state_nxt = FLUSH;
        end else begin
            case (state)
                BOOT:  state_nxt = RUN;
                RUN: begin
                    if (accept) begin
                        if (is_halt) state_nxt = HALT;
                        else         pc_nxt    = bus.next_pc;
                    end
                end
                FLUSH: state_nxt = RUN;
                HALT: begin
                    if (bus.resume) begin
                        pc_nxt    = bus.next_pc;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Counts every accepted instruction, including one accepted alongside a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cnt <= '0;
        else if (accept) cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_fetch_pc_seq.sv
// Bench for fetch_pc_seq: directed scenarios plus randomized traffic, all checked
// against a bubble/halted reference model of the fetch stream.
module tb_fetch_pc_seq;
    localparam int PC_W = 4, INSTR_W = 8, CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_pc_seq_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus();

    fetch_pc_seq #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(4'd0), .HALT_OP(4'hF),
                   .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [16];
    assign bus.imem_rdata = mem[bus.imem_addr];
    assign bus.next_pc    = bus.br_sel ? bus.br_tgt : bus.pc_inc;

    // Reference: pc, accepted count, and whether a bubble cycle (boot/flush) or halt is pending.
    int m_pc, m_cnt;
    bit m_bub, m_halt;
    int vec = 0, bad = 0;

    wire [34:0] obs = {bus.if_valid, bus.if_pc, bus.if_instr, bus.halted, bus.fetch_cnt,
                       bus.br_sel, bus.pc_inc, bus.br_tgt, bus.imem_addr};

    function automatic logic [34:0] expv();
        logic v;
        logic [3:0] p;
        p = m_pc[3:0];
        v = !m_bub && !m_halt;
        return {v, v ? p : 4'd0, v ? mem[p] : 8'd0, m_halt, m_cnt[7:0],
                bus.br_req, p + 4'd1, bus.br_target, p};
    endfunction

    task automatic fill_mem(input bit allow_halt);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            if (allow_halt && ($urandom % 8 == 0)) op = 4'hF;
            mem[i] = {op, 4'($urandom)};
        end
    endtask

    task automatic drive(input logic br, input logic [3:0] tgt, input logic rdy, input logic res);
        bus.br_req = br; bus.br_target = tgt; bus.id_ready = rdy; bus.resume = res;
        #1;
    endtask

    task automatic tick();
        bit acc;
        logic [3:0] op;
        @(posedge clk);
        if (!rst) begin
            acc = !m_bub && !m_halt && bus.id_ready;
            op  = mem[m_pc[3:0]][7:4];
            if (acc) m_cnt = (m_cnt + 1) % 256;
            if (bus.br_req) begin
                m_pc = int'(bus.br_target); m_bub = 1; m_halt = 0;
            end else if (m_bub) begin
                m_bub = 0;
            end else if (m_halt) begin
                if (bus.resume) begin m_pc = (m_pc + 1) % 16; m_halt = 0; end
            end else if (acc) begin
                if (op == 4'hF) m_halt = 1;
                else            m_pc = (m_pc + 1) % 16;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_bub = 1; m_halt = 0;
    endtask

    // Entered at a negedge; pulses reset mid-cycle and returns at a negedge with reset released.
    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 4'd0, 1, 0);
        if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.halted, bus.fetch_cnt, bus.imem_addr} !== 26'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {bus.if_valid, bus.if_instr, bus.if_pc, bus.halted, bus.fetch_cnt, bus.imem_addr});
        end
        vec++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(0, 4'd0, 1, 0);
        if (bus.if_valid !== 1'b0 || obs !== expv()) begin
            bad++; $display("FAIL boot_bubble got=%h exp=%h", obs, expv());
        end
        vec++;
        tick();
        drive(0, 4'd0, 1, 0);
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 4'd0 || obs !== expv()) begin
            bad++; $display("FAIL first_valid got=%h exp=%h", obs, expv());
        end
        vec++;
    endtask

    task automatic test_wrap();
        fill_mem(0);
        do_reset();
        tick();
        for (int i = 0; i < 270; i++) begin
            drive(0, 4'd0, 1, 0);
            if (bus.if_pc !== 4'(i) || bus.fetch_cnt !== 8'(i) || obs !== expv()) begin
                bad++; $display("FAIL wrap c%0d got=%h exp=%h", i, obs, expv());
            end
            vec++;
            tick();
        end
    endtask

    task automatic test_stall();
        fill_mem(0);
        do_reset();
        for (int i = 0; i < 6; i++) begin drive(0, 4'd0, 1, 0); tick(); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'd0, 0, 0);
            if (bus.if_pc !== 4'd5 || bus.if_instr !== mem[5] || bus.fetch_cnt !== 8'd5 || obs !== expv()) begin
                bad++; $display("FAIL stall c%0d got=%h exp=%h", i, obs, expv());
            end
            vec++;
            tick();
        end
        drive(0, 4'd0, 1, 0);
        tick();
        drive(0, 4'd0, 1, 0);
        if (bus.if_pc !== 4'd6 || bus.fetch_cnt !== 8'd6 || obs !== expv()) begin
            bad++; $display("FAIL stall_release got=%h exp=%h", obs, expv());
        end
        vec++;
    endtask

    task automatic test_branch();
        fill_mem(0);
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(0, 4'd0, 1, 0); tick(); end
        drive(1, 4'hC, 1, 0);
        if (bus.if_pc !== 4'd3 || bus.br_sel !== 1'b1 || bus.next_pc !== 4'hC || obs !== expv()) begin
            bad++; $display("FAIL branch_sel got=%h exp=%h", obs, expv());
        end
        vec++;
        tick();
        drive(0, 4'd0, 1, 0);
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 4'hC || bus.fetch_cnt !== 8'd4 || obs !== expv()) begin
            bad++; $display("FAIL branch_flush got=%h exp=%h", obs, expv());
        end
        vec++;
        tick();
        drive(0, 4'd0, 1, 0);
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 4'hC || obs !== expv()) begin
            bad++; $display("FAIL branch_target got=%h exp=%h", obs, expv());
        end
        vec++;
        drive(1, 4'h1, 1, 0); tick();
        drive(1, 4'h9, 1, 0);
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 4'h1 || obs !== expv()) begin
            bad++; $display("FAIL b2b_branch got=%h exp=%h", obs, expv());
        end
        vec++;
        tick();
        drive(0, 4'd0, 1, 0);
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 4'h9 || obs !== expv()) begin
            bad++; $display("FAIL b2b_flush got=%h exp=%h", obs, expv());
        end
        vec++;
        tick();
    endtask

    task automatic test_halt();
        fill_mem(0);
        mem[7] = {4'hF, 4'h3};
        do_reset();
        for (int i = 0; i < 8; i++) begin drive(0, 4'd0, 1, 0); tick(); end
        drive(0, 4'd0, 1, 0);
        if (bus.if_pc !== 4'd7 || bus.if_instr !== 8'hF3 || obs !== expv()) begin
            bad++; $display("FAIL halt_fetch got=%h exp=%h", obs, expv());
        end
        vec++;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'd0, 1, 0);
            if (bus.halted !== 1'b1 || bus.if_valid !== 1'b0 || bus.imem_addr !== 4'd7 ||
                bus.fetch_cnt !== 8'd8 || obs !== expv()) begin
                bad++; $display("FAIL halted c%0d got=%h exp=%h", i, obs, expv());
            end
            vec++;
            tick();
        end
        drive(0, 4'd0, 1, 1);
        if (bus.next_pc !== 4'd8 || obs !== expv()) begin
            bad++; $display("FAIL resume_mux got=%h exp=%h", obs, expv());
        end
        vec++;
        tick();
        drive(0, 4'd0, 1, 0);
        if (bus.halted !== 1'b0 || bus.if_valid !== 1'b1 || bus.if_pc !== 4'd8 || obs !== expv()) begin
            bad++; $display("FAIL resume_run got=%h exp=%h", obs, expv());
        end
        vec++;
        drive(0, 4'd0, 1, 1); tick();
        drive(0, 4'd0, 1, 0);
        if (bus.if_pc !== 4'd9 || bus.halted !== 1'b0 || obs !== expv()) begin
            bad++; $display("FAIL resume_ignored got=%h exp=%h", obs, expv());
        end
        vec++;
    endtask

    task automatic test_halt_branch();
        fill_mem(0);
        mem[7] = {4'hF, 4'h0};
        do_reset();
        for (int i = 0; i < 8; i++) begin drive(0, 4'd0, 1, 0); tick(); end
        drive(1, 4'd2, 1, 0);
        tick();
        drive(0, 4'd0, 1, 0);
        if (bus.halted !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_addr !== 4'd2 ||
            bus.fetch_cnt !== 8'd8 || obs !== expv()) begin
            bad++; $display("FAIL halt_branch got=%h exp=%h", obs, expv());
        end
        vec++;
        tick();
        drive(0, 4'd0, 1, 0);
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 4'd2 || obs !== expv()) begin
            bad++; $display("FAIL halt_branch_run got=%h exp=%h", obs, expv());
        end
        vec++;
    endtask

    task automatic test_reset_mid();
        fill_mem(0);
        mem[4] = {4'hF, 4'h1};
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(0, 4'd0, 1, 0); tick(); end
        drive(1, 4'hA, 1, 0); tick();
        drive(0, 4'd0, 1, 0);
        #2 rst = 1'b1;
        #1;
        if ({bus.if_valid, bus.if_pc, bus.halted, bus.fetch_cnt, bus.imem_addr} !== 18'd0) begin
            bad++; $display("FAIL reset_mid_flush got=%h exp=0", {bus.if_valid, bus.if_pc, bus.halted, bus.fetch_cnt, bus.imem_addr});
        end
        vec++;
        model_reset();
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin drive(0, 4'd0, 1, 0); tick(); end
        if (bus.halted !== 1'b1 || obs !== expv()) begin
            bad++; $display("FAIL reset_mid_setup got=%h exp=%h", obs, expv());
        end
        vec++;
        #2 rst = 1'b1;
        #1;
        if ({bus.if_valid, bus.if_pc, bus.halted, bus.fetch_cnt, bus.imem_addr} !== 18'd0) begin
            bad++; $display("FAIL reset_mid_halt got=%h exp=0", {bus.if_valid, bus.if_pc, bus.halted, bus.fetch_cnt, bus.imem_addr});
        end
        vec++;
        model_reset();
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_random();
        fill_mem(1);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 10) == 0, 4'($urandom), ($urandom % 4) != 0, ($urandom % 6) == 0);
            if (obs !== expv()) begin
                bad++; $display("FAIL random c%0d got=%h exp=%h", i, obs, expv());
            end
            vec++;
            if ($urandom % 150 == 0) do_reset();
            else                     tick();
            if (i % 100 == 99) fill_mem(1);
        end
    endtask

    initial begin
        bus.br_req = 1'b0; bus.br_target = '0; bus.id_ready = 1'b0; bus.resume = 1'b0;
        fill_mem(0);
        model_reset();
        @(negedge clk);
        test_reset();
        tick();
        test_wrap();
        test_stall();
        test_branch();
        test_halt();
        test_halt_branch();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
